// File: rtl/kalman_mul_arbiter.sv
// kalman_mul_arbiter
// Time-shares one signed fixed-point (Q2.14 at defaults) multiplier between
// NREQ requesters of the Kalman filter pipeline. A round-robin arbiter issues
// at most one grant per cycle; the granted operands go through a PIPE-deep
// pipeline and the saturated result comes back one-hot to the issuing lane.
//
// Build option: define KALMAN_MUL_ROUND_EN to round half up before
// saturation instead of truncating toward -inf. Latency and ports are the
// same in both builds.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   en_i         grant enable; low blocks new grants, pipeline still drains
//   req_i        per-requester level request, held until granted
//   op_a_i       packed operand A, lane i at [i*WIDTH +: WIDTH]
//   op_b_i       packed operand B, same packing
//   sat_clr_i    synchronous clear of the saturation counter (wins over +1)
//   gnt_o        one-hot grant (combinational)
//   rsp_valid_o  one-hot response strobe (registered)
//   rsp_data_o   result, meaningful while any rsp_valid_o bit is set
//   rsp_sat_o    result was clamped; qualified by rsp_valid_o
//   busy_o       some pipeline stage holds an operation
//   sat_cnt_o    saturating count of clamped results
module kalman_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int PIPE  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   op_a_i,
    input  logic [NREQ*WIDTH-1:0]   op_b_i,
    input  logic                    sat_clr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         rsp_valid_o,
    output logic [WIDTH-1:0]        rsp_data_o,
    output logic                    rsp_sat_o,
    output logic                    busy_o,
    output logic [7:0]              sat_cnt_o
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Clamp bounds, sign-extended to the width of the shifted product.
    localparam logic signed [2*WIDTH:0] SMAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH:0] SMIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef KALMAN_MUL_ROUND_EN
    localparam logic signed [2*WIDTH:0] HALF = {{(2*WIDTH){1'b0}}, 1'b1} << (FRAC-1);
`endif

    // Returns {saturated, result}. The product is widened by one bit so the
    // rounding add can never wrap.
    function automatic logic [WIDTH:0] sat_mul(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH:0]   ext;
        logic signed [2*WIDTH:0]   q;
        logic [WIDTH:0]            res;
        prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        ext  = {prod[2*WIDTH-1], prod};
`ifdef KALMAN_MUL_ROUND_EN
        ext  = ext + HALF;
`endif
        q = ext >>> FRAC;
        if (q > SMAX) begin
            res = {1'b1, SMAX[WIDTH-1:0]};
        end else if (q < SMIN) begin
            res = {1'b1, SMIN[WIDTH-1:0]};
        end else begin
            res = {1'b0, q[WIDTH-1:0]};
        end
        return res;
    endfunction

    logic [IDXW-1:0]        rr_q, rr_d;
    logic [NREQ-1:0]        gnt_s;
    logic [IDXW-1:0]        gidx_s;
    logic                   hit_s;
    logic [WIDTH-1:0]       a_sel_s, b_sel_s;
    logic [WIDTH:0]         mul_s;
    logic [WIDTH-1:0]       res_d;
    logic                   sat_d;
    logic [NREQ-1:0]        oh_q  [PIPE];
    logic [WIDTH-1:0]       res_q [PIPE];
    logic                   sat_q [PIPE];
    logic [7:0]             sat_cnt_q, sat_cnt_d;
    logic                   rsp_fire_s;
    logic                   busy_s;

    // Round-robin scan starting at rr_q; the first pending lane wins.
    always_comb begin
        logic [IDXW-1:0] cand;
        gnt_s  = '0;
        gidx_s = '0;
        hit_s  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDXW'((int'(rr_q) + k) % NREQ);
            if (!hit_s && en_i && rst_ni && req_i[cand]) begin
                gnt_s[cand] = 1'b1;
                gidx_s      = cand;
                hit_s       = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        if (hit_s) begin
            rr_d = IDXW'((int'(gidx_s) + 1) % NREQ);
        end else begin
            rr_d = rr_q;
        end
    end

    // One-hot AND-OR operand mux; the multiply sits ahead of the first stage
    // so every PIPE value shares the same structure.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_sel_s = a_sel_s | (op_a_i[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
            b_sel_s = b_sel_s | (op_b_i[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
        end
        mul_s = sat_mul(a_sel_s, b_sel_s);
        if (hit_s) begin
            res_d = mul_s[WIDTH-1:0];
            sat_d = mul_s[WIDTH];
        end else begin
            res_d = '0;
            sat_d = 1'b0;
        end
    end

    // Saturation counter next state; clear beats increment, holds at 255.
    always_comb begin
        rsp_fire_s = |oh_q[PIPE-1];
        if (sat_clr_i) begin
            sat_cnt_d = 8'd0;
        end else if (rsp_fire_s && sat_q[PIPE-1] && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // busy is the OR of every stage's one-hot tag.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < PIPE; k++) begin
            busy_s = busy_s | (|oh_q[k]);
        end
    end

    // Arbiter pointer, result pipeline and saturation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            sat_cnt_q <= 8'd0;
            for (int k = 0; k < PIPE; k++) begin
                oh_q[k]  <= '0;
                res_q[k] <= '0;
                sat_q[k] <= 1'b0;
            end
        end else begin
            rr_q      <= rr_d;
            sat_cnt_q <= sat_cnt_d;
            oh_q[0]   <= gnt_s;
            res_q[0]  <= res_d;
            sat_q[0]  <= sat_d;
            for (int k = 1; k < PIPE; k++) begin
                oh_q[k]  <= oh_q[k-1];
                res_q[k] <= res_q[k-1];
                sat_q[k] <= sat_q[k-1];
            end
        end
    end

    assign gnt_o       = gnt_s;
    assign rsp_valid_o = oh_q[PIPE-1];
    assign rsp_data_o  = res_q[PIPE-1];
    assign rsp_sat_o   = sat_q[PIPE-1];
    assign busy_o      = busy_s;
    assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_kalman_mul_arbiter.sv
// Self-checking bench for kalman_mul_arbiter: directed scenarios plus a
// randomized phase, checked every cycle against a schedule-based model.
module tb_kalman_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int PIPE  = 2;
    localparam int MAXV  = 2**(WIDTH-1) - 1;
    localparam int MINV  = -(2**(WIDTH-1));

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  sat_clr = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] op_a = '0;
    logic [NREQ*WIDTH-1:0] op_b = '0;
    logic [NREQ-1:0]       gnt_o, rsp_valid_o;
    logic [WIDTH-1:0]      rsp_data_o;
    logic                  rsp_sat_o, busy_o;
    logic [7:0]            sat_cnt_o;

    int checks = 0;
    int errors = 0;

    kalman_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FRAC(FRAC), .PIPE(PIPE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req),
        .op_a_i(op_a), .op_b_i(op_b), .sat_clr_i(sat_clr),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .rsp_sat_o(rsp_sat_o), .busy_o(busy_o), .sat_cnt_o(sat_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from the rules: exact product, floor shift, clamp.
    function automatic void ref_mul(input int a, input int b, output int r, output int s);
        longint p, q;
        p = longint'(a) * longint'(b);
`ifdef KALMAN_MUL_ROUND_EN
        p = p + (longint'(1) <<< (FRAC-1));
`endif
        q = p >>> FRAC;
        if (q > MAXV) begin r = MAXV; s = 1; end
        else if (q < MINV) begin r = MINV; s = 1; end
        else begin r = int'(q); s = 0; end
    endfunction

    // Model state: responses keyed by the cycle they must appear in.
    int rr_m = 0;
    int satc_m = 0;
    int cyc = 0;
    int s_idx[int];
    int s_dat[int];
    int s_sat[int];

    // Compare process: checks every cycle at the falling edge, then advances
    // the model to account for the coming rising edge.
    initial forever begin
        int g, gi, r, s, a, b;
        @(negedge clk);
        if (!rst_n) begin
            s_idx.delete(); s_dat.delete(); s_sat.delete();
            rr_m = 0;
            satc_m = 0;
            chk("rst_data", longint'(rsp_data_o), 0);
            chk("rst_sat", longint'(rsp_sat_o), 0);
        end
        chk("busy", longint'(busy_o), longint'(s_idx.num() != 0));
        chk("sat_cnt", longint'(sat_cnt_o), satc_m);
        if (s_idx.exists(cyc)) begin
            chk("rsp_valid", longint'(rsp_valid_o), longint'(1) << s_idx[cyc]);
            chk("rsp_data", longint'($signed(rsp_data_o)), s_dat[cyc]);
            chk("rsp_sat", longint'(rsp_sat_o), s_sat[cyc]);
            if (s_sat[cyc] != 0 && satc_m < 255) satc_m++;
            s_idx.delete(cyc); s_dat.delete(cyc); s_sat.delete(cyc);
        end else begin
            chk("rsp_idle", longint'(rsp_valid_o), 0);
        end
        if (rst_n && sat_clr) satc_m = 0;
        g = 0;
        gi = -1;
        if (rst_n && en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && req[(rr_m + k) % NREQ]) gi = (rr_m + k) % NREQ;
            end
        end
        if (gi >= 0) g = 1 << gi;
        chk("gnt", longint'(gnt_o), g);
        if (gi >= 0) begin
            a = int'($signed(op_a[gi*WIDTH +: WIDTH]));
            b = int'($signed(op_b[gi*WIDTH +: WIDTH]));
            ref_mul(a, b, r, s);
            s_idx[cyc + PIPE] = gi;
            s_dat[cyc + PIPE] = r;
            s_sat[cyc + PIPE] = s;
            rr_m = (gi + 1) % NREQ;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input int a, input int b);
        op_a[lane*WIDTH +: WIDTH] = 16'(a);
        op_b[lane*WIDTH +: WIDTH] = 16'(b);
    endtask

    // Lone request on one lane with literal expectations on the response.
    task automatic one_op(input int lane, input int a, input int b,
                          input int exp_d, input int exp_s);
        set_lane(lane, a, b);
        req = 4'(1 << lane);
        tick();
        req = '0;
        tick();
        chk("lit_vld", longint'(rsp_valid_o), longint'(1) << lane);
        chk("lit_data", longint'($signed(rsp_data_o)), exp_d);
        chk("lit_sat", longint'(rsp_sat_o), exp_s);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int r, s;
        logic [NREQ-1:0] seq [8];
        logic [NREQ-1:0] g;
        int rnd_d0, rnd_d1;

        // Pin the reference model itself with hand-computed values.
        ref_mul(16384, 16384, r, s);   chk("pin_one", r, 16384);
        ref_mul(8192, 8192, r, s);     chk("pin_quarter", r, 4096);
        ref_mul(32767, 32767, r, s);   chk("pin_satp", r, 32767); chk("pin_satp_f", s, 1);
        ref_mul(-32768, 32767, r, s);  chk("pin_satn", r, -32768); chk("pin_satn_f", s, 1);
`ifdef KALMAN_MUL_ROUND_EN
        rnd_d0 = 1;  rnd_d1 = 0;
`else
        rnd_d0 = 0;  rnd_d1 = -1;
`endif
        ref_mul(1, 8192, r, s);        chk("pin_rnd0", r, rnd_d0);
        ref_mul(-1, 1, r, s);          chk("pin_rnd1", r, rnd_d1);

        // Reset state.
        repeat (3) tick();
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_gnt", longint'(gnt_o), 0);
        rst_n = 1'b1;
        en = 1'b1;

        // Basic multiplies.
        one_op(0, 16384, 16384, 16384, 0);
        one_op(0, 8192, 8192, 4096, 0);

        // Round-robin with all four lanes, distinct operands.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, 4096 * (i + 1), 16384);
        req = 4'hF;
        for (int n = 0; n < 8; n++) begin
            #1 seq[n] = gnt_o;
            tick();
        end
        req = '0;
        for (int n = 0; n < 8; n++) chk("rr_seq", longint'(seq[n]), longint'(1) << (n % 4));
        repeat (4) tick();

        // Saturation and the counter.
        do_reset();
        one_op(0, 32767, 32767, 32767, 1);
        chk("sat_cnt1", longint'(sat_cnt_o), 1);
        one_op(0, -32768, 32767, -32768, 1);
        chk("sat_cnt2", longint'(sat_cnt_o), 2);
        set_lane(0, 32767, 32767);
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_clr_hit", longint'(sat_cnt_o), 0);
        set_lane(1, 32767, 32767);
        req = 4'b0010;
        repeat (300) tick();
        req = '0;
        repeat (4) tick();
        chk("sat_cnt255", longint'(sat_cnt_o), 255);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_clr", longint'(sat_cnt_o), 0);

        // Rounding corner cases.
        one_op(2, 1, 8192, rnd_d0, 0);
        one_op(3, -1, 1, rnd_d1, 0);

        // Enable gating with an operation in flight.
        do_reset();
        set_lane(0, 8192, 8192);
        req = 4'b0001;
        tick();
        en = 1'b0;
        req = 4'b0110;
        set_lane(1, 16384, -16384);
        set_lane(2, -8192, 8192);
        for (int n = 0; n < 3; n++) begin
            #1 chk("en_block", longint'(gnt_o), 0);
            tick();
        end
        en = 1'b1;
        #1 chk("en_first", longint'(gnt_o), 4'b0010);
        tick();
        req = 4'b0100;
        #1 chk("en_second", longint'(gnt_o), 4'b0100);
        tick();
        req = '0;
        repeat (4) tick();

        // Reset in the middle of an operation.
        do_reset();
        set_lane(2, 16384, 16384);
        req = 4'b0100;
        tick();
        rst_n = 1'b0;
        req = '0;
        tick();
        rst_n = 1'b1;
        chk("mid_vld", longint'(rsp_valid_o), 0);
        chk("mid_busy", longint'(busy_o), 0);
        chk("mid_satcnt", longint'(sat_cnt_o), 0);
        req = 4'hF;
        #1 chk("mid_first", longint'(gnt_o), 4'b0001);
        tick();
        req = '0;
        repeat (4) tick();

        // Randomized traffic; a pending lane keeps req and operands stable.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1 g = gnt_o;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || g[i]) begin
                    req[i] = ($urandom_range(0, 9) < 6);
                    if ($urandom_range(0, 3) == 0)
                        set_lane(i, ($urandom_range(0, 1) != 0) ? 32767 - int'($urandom_range(0, 3000))
                                                                 : -32768 + int'($urandom_range(0, 3000)),
                                 ($urandom_range(0, 1) != 0) ? 32767 : -32768);
                    else
                        set_lane(i, int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(0, 65535)) - 32768);
                end
            end
            en = ($urandom_range(0, 9) != 0);
            sat_clr = ($urandom_range(0, 39) == 0);
        end
        req = '0;
        sat_clr = 1'b0;
        en = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kalman_mul_arbiter.md
Name: kalman_mul_arbiter

Overview:
- Shares one signed Q2.14 fixed-point multiplier between up to NREQ requesters of the Kalman filter pipeline: predict, gain, state-update and covariance-update stages.
- Round-robin arbitration, one grant per cycle, fixed-latency pipelined multiply.
- Each result is returned one-hot to the requester that issued the operands.
- Lets the filter core replace its per-stage multiplier arrays with a single time-shared unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand/result width, signed two's complement.
- FRAC, 14, fractional bits (Q2.14 at defaults).
- PIPE, 2, cycles from grant to response (1..4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; low blocks new grants, in-flight operations still complete.
- req  in  NREQ  per-requester request, level, held until granted.
- op_a  in  NREQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- op_b  in  NREQ*WIDTH  packed operand B, same packing.
- gnt  out  NREQ  one-hot grant, combinational, at most one bit set.
- rsp_valid  out  NREQ  one-hot response strobe, registered.
- rsp_data  out  WIDTH  result, registered; valid only while any rsp_valid bit is high.
- rsp_sat  out  1  current result was saturated; qualified by rsp_valid.
- busy  out  1  any pipeline stage holds a valid operation.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  8  saturating count of saturated results.

Behaviour:
- Reset (reset=0, async): all pipeline valid bits 0, rr_ptr=0, sat_cnt=0. rsp_valid=0, rsp_data=0, rsp_sat=0, busy=0. gnt=0 while reset is asserted.
- Reset mid-operation: in-flight operations are discarded; no rsp_valid is produced for them after release.
- Arbitration:
  - gnt[i]=1 when en=1, req[i]=1, and i is the first requester set scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - At the rising edge while gnt[i]=1, op_a/op_b slice i are captured together with index i.
  - rr_ptr then becomes (i+1) mod NREQ; rr_ptr is unchanged when no grant occurs.
- Requester rules:
  - Hold req and operands stable until the edge at which gnt is high.
  - Deasserting req before grant withdraws the request with no side effects.
  - Keeping req high after grant issues a new request.
- Throughput: one grant per cycle; no backpressure on responses.
- Latency: gnt[i] high in cycle c gives rsp_valid[i] high in cycle c+PIPE for exactly one cycle, with rsp_data and rsp_sat in the same cycle. Responses return in grant order.
- Arithmetic:
  - p = signed(a)*signed(b), 2*WIDTH bits.
  - q = p >>> FRAC (arithmetic shift, truncation toward -inf).
  - If q > 2^(WIDTH-1)-1, result = 2^(WIDTH-1)-1 and rsp_sat=1.
  - If q < -2^(WIDTH-1), result = -2^(WIDTH-1) and rsp_sat=1.
  - Otherwise result = q[WIDTH-1:0] and rsp_sat=0.
- sat_cnt:
  - Increments on each rsp_valid cycle with rsp_sat=1.
  - Holds at 255.
  - sat_clr has priority: if a saturation and sat_clr coincide, sat_cnt becomes 0.
- busy: OR of all pipeline-stage valid bits. Goes high the cycle after a grant and low the cycle after the last rsp_valid.
- Pipeline: internal state is the stage-valid shift register (PIPE deep) plus rr_ptr; no other FSM.
- en=0 with req pending: no gnt, rr_ptr frozen; the pipeline drains normally.

Optional Feature:
- Macro: KALMAN_MUL_ROUND_EN.
- Defined: q = (p + 2^(FRAC-1)) >>> FRAC (round half up) before saturation; the add is done in 2*WIDTH+1 bits so it cannot overflow.
- Undefined: truncation as in Behaviour.
- Latency and interface are identical in both builds.

Test Plan:
- Basic multiply, req[0] only (defaults): a=16384, b=16384 -> rsp_valid[0] exactly 2 cycles after gnt[0], rsp_data=16384, rsp_sat=0. a=8192, b=8192 -> rsp_data=4096.
- Round-robin, all four req held high for 8 cycles -> gnt sequence 1,2,4,8,1,2,4,8 (one-hot), rsp_valid matches the same sequence delayed 2 cycles. Distinct operands per requester -> each result lands on the correct index.
- Saturation:
  - a=32767, b=32767 -> rsp_data=32767, rsp_sat=1, sat_cnt=1.
  - a=-32768, b=32767 -> rsp_data=-32768, sat_cnt=2.
  - sat_clr in the same cycle as a third saturation -> sat_cnt=0.
  - 300 saturations -> sat_cnt=255.
- Rounding:
  - a=1, b=8192 -> 0 without the macro, 1 with KALMAN_MUL_ROUND_EN.
  - a=-1, b=1 -> -1 without the macro, 0 with it.
- Enable: en=0 while req=4'b0110 -> no gnt. en rises -> gnt=4'b0010 first when rr_ptr=0; in-flight results still return during en=0.
- Reset mid-op: grant req[2], assert reset the next cycle for 1 cycle -> no rsp_valid appears, busy=0, sat_cnt=0. After release with req=4'b1111 -> first gnt=4'b0001.
